// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner with press/release debounce and a one-deep key register.
// A key is accepted one cycle after its press debounce; a key arriving while key_valid is still set is dropped and flags overrun.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 50_000,
    parameter int DEBOUNCE_MAX = 999_999
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       overrun
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_MAX > 0) ? $clog2(DEBOUNCE_MAX + 1) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_MAX - 1);

    typedef enum logic [2:0] {
        IDLE, SCAN, DEBOUNCE, PRESSED, HOLD, RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        col_q, col_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        row_lat_q, row_lat_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0]        row_s1_q, row_s1_d;
    logic [3:0]        row_s_q, row_s_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              overrun_q, overrun_d;

    logic [3:0] col_next;
    logic       row_onehot;
    logic       key_load;
    logic       key_lost;
    logic       key_taken;

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        if (oh[3]) idx = 2'd3;
        return idx;
    endfunction

    assign col_next   = {col_q[2:0], col_q[3]};
    assign row_onehot = (row_s_q != 4'd0) && ((row_s_q & (row_s_q - 4'd1)) == 4'd0);

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        scan_cnt_d = scan_cnt_q;
        deb_cnt_d  = deb_cnt_q;
        row_lat_d  = row_lat_q;
        col_idx_d  = col_idx_q;
        row_s1_d   = row;
        row_s_d    = row_s1_q;

        if (!enable) begin
            state_d    = IDLE;
            col_d      = 4'd0;
            scan_cnt_d = '0;
            deb_cnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SCAN;
                    col_d      = 4'b0001;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                end
                SCAN: begin
                    if (scan_cnt_q == SCAN_LAST) begin
                        if (row_onehot) begin
                            state_d   = DEBOUNCE;
                            row_lat_d = row_s_q;
                            col_idx_d = onehot_idx(col_q);
                            deb_cnt_d = '0;
                        end else begin
                            col_d      = col_next;
                            scan_cnt_d = '0;
                        end
                    end else begin
                        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (deb_cnt_q == DEB_LAST) begin
                        if (row_s_q == row_lat_q) begin
                            state_d = PRESSED;
                        end else begin
                            state_d    = SCAN;
                            col_d      = col_next;
                            scan_cnt_d = '0;
                        end
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end
                PRESSED: state_d = HOLD;
                HOLD: begin
                    if (row_s_q == 4'd0) begin
                        state_d   = RELEASE;
                        deb_cnt_d = '0;
                    end
                end
                RELEASE: begin
                    if (deb_cnt_q == DEB_LAST) begin
                        if (row_s_q == 4'd0) begin
                            state_d    = SCAN;
                            col_d      = col_next;
                            scan_cnt_d = '0;
                        end else begin
                            state_d = HOLD;
                        end
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    col_d   = 4'd0;
                end
            endcase
        end
    end

    // A key may replace the held one only if it is consumed in the very same cycle.
    assign key_taken = key_valid_q && key_ack;
    assign key_load  = enable && (state_q == PRESSED) && (!key_valid_q || key_ack);
    assign key_lost  = enable && (state_q == PRESSED) && key_valid_q && !key_ack;

    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overrun_d   = overrun_q;
        if (key_load) begin
            key_code_d  = {onehot_idx(row_lat_q), col_idx_q};
            key_valid_d = 1'b1;
        end else if (key_taken) begin
            key_valid_d = 1'b0;
        end
        if (key_lost) begin
            overrun_d = 1'b1;
        end else if (key_taken) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            col_q       <= 4'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            row_lat_q   <= 4'd0;
            col_idx_q   <= 2'd0;
            row_s1_q    <= 4'd0;
            row_s_q     <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            row_lat_q   <= row_lat_d;
            col_idx_q   <= col_idx_d;
            row_s1_q    <= row_s1_d;
            row_s_q     <= row_s_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a 4x4 keypad model answers the column drive, and a
// key-level model (accepted key, overrun flag, latency bound) judges the outputs.
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_MAX = 8;
    localparam int LAT_MAX      = 2 + 4 * SCAN_DIV + DEBOUNCE_MAX + 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       key_ack = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       overrun;

    logic       key_down = 1'b0;
    logic [1:0] key_r = 2'd0;
    logic [1:0] key_c = 2'd0;
    logic       row_force_en = 1'b0;
    logic [3:0] row_force = 4'd0;

    int checks = 0;
    int errors = 0;

    logic       exp_valid;
    logic [3:0] exp_code;
    logic       exp_ovr;

    keypad_scan_ctrl #(
        .SCAN_DIV    (SCAN_DIV),
        .DEBOUNCE_MAX(DEBOUNCE_MAX)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_ack  (key_ack),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    // Pressed switch connects its column to its row; forced values model glitches and multi-key contact.
    always_comb begin
        if (row_force_en)
            row = row_force;
        else if (key_down && col[key_c])
            row = 4'b0001 << key_r;
        else
            row = 4'b0000;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (key_valid !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        key_r    = r;
        key_c    = c;
        key_down = 1'b1;
    endtask

    task automatic release_key;
        key_down = 1'b0;
        tick(3 * DEBOUNCE_MAX + 8 * SCAN_DIV);
    endtask

    task automatic ack_pulse;
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
    endtask

    task automatic wait_col(input logic [3:0] want, output logic found);
        int n;
        n = 0;
        while (col !== want && n < 100) begin
            @(negedge clock);
            n++;
        end
        found = (col === want);
    endtask

    initial begin
        int         lat;
        int         n;
        int         stable;
        logic       found;
        logic [3:0] seen;
        logic [3:0] prev;
        logic [3:0] col_exp;
        logic [1:0] r;
        logic [1:0] c;

        // Reset state
        tick(3);
        check_eq("rst_col", col, 4'd0);
        check_eq("rst_code", key_code, 4'd0);
        check_eq("rst_valid", key_valid, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);

        // Idle scanning: each column for SCAN_DIV clocks in rotation
        enable = 1'b1;
        reset  = 1'b1;
        n = 0;
        while (col === 4'd0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        for (int k = 0; k < 4 * SCAN_DIV * 2; k++) begin
            col_exp = 4'b0001 << ((k / SCAN_DIV) % 4);
            check_eq("col_cycle", col, col_exp);
            tick(1);
        end
        check_eq("idle_no_key", key_valid, 1'b0);

        // Single press at row 2 / column 1
        press(2'd2, 2'd1);
        wait_valid(lat);
        check_eq("press_latency_ok", lat <= LAT_MAX, 1'b1);
        check_eq("press_code", key_code, 4'b1001);
        tick(10);
        check_eq("valid_until_ack", key_valid, 1'b1);
        ack_pulse();
        check_eq("ack_clears_valid", key_valid, 1'b0);
        tick(40);
        check_eq("no_autorepeat", key_valid, 1'b0);
        release_key();
        check_eq("one_key_per_press", key_valid, 1'b0);
        check_eq("no_overrun_single", overrun, 1'b0);

        // Three-clock glitch on column 0 must not produce a key
        wait_col(4'b1000, found);
        wait_col(4'b0001, found);
        check_eq("glitch_align", found, 1'b1);
        row_force    = 4'b0001;
        row_force_en = 1'b1;
        tick(3);
        row_force_en = 1'b0;
        wait_col(4'b1000, found);
        check_eq("glitch_scan_resumes", found, 1'b1);
        check_eq("glitch_no_key", key_valid, 1'b0);

        // Two rows at once are ignored; every column still gets visited
        row_force    = 4'b0011;
        row_force_en = 1'b1;
        seen = 4'd0;
        for (int k = 0; k < 10 * SCAN_DIV; k++) begin
            tick(1);
            seen = seen | col;
        end
        row_force_en = 1'b0;
        check_eq("multi_all_cols", seen, 4'b1111);
        check_eq("multi_no_key", key_valid, 1'b0);
        tick(4);

        // Two presses without ack: first kept, overrun raised; ack clears both
        press(2'd0, 2'd3);
        tick(LAT_MAX + 2);
        check_eq("ovr_first_valid", key_valid, 1'b1);
        check_eq("ovr_first_code", key_code, 4'b0011);
        release_key();
        press(2'd3, 2'd0);
        tick(LAT_MAX + 2);
        check_eq("ovr_code_kept", key_code, 4'b0011);
        check_eq("ovr_set", overrun, 1'b1);
        release_key();
        ack_pulse();
        check_eq("ovr_ack_valid", key_valid, 1'b0);
        check_eq("ovr_ack_clear", overrun, 1'b0);
        ack_pulse();
        check_eq("stray_ack_ignored", key_valid, 1'b0);

        // Random presses against a key-level model
        exp_valid = 1'b0;
        exp_code  = 4'd0;
        exp_ovr   = 1'b0;
        for (int it = 0; it < 12; it++) begin
            r = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            press(r, c);
            tick(LAT_MAX + 2);
            if (!exp_valid) begin
                exp_valid = 1'b1;
                exp_code  = {r, c};
            end else begin
                exp_ovr = 1'b1;
            end
            release_key();
            check_eq("rnd_valid", key_valid, exp_valid);
            check_eq("rnd_code", key_code, exp_code);
            check_eq("rnd_overrun", overrun, exp_ovr);
            if ($urandom_range(0, 1) == 1) begin
                ack_pulse();
                exp_valid = 1'b0;
                exp_ovr   = 1'b0;
                check_eq("rnd_ack_valid", key_valid, exp_valid);
                check_eq("rnd_ack_overrun", overrun, exp_ovr);
            end
        end

        // Reset during debounce clears everything at once
        press(2'd1, 2'd1);
        tick(LAT_MAX + 2);
        release_key();
        check_eq("pre_rst_valid", key_valid, 1'b1);
        press(2'd2, 2'd3);
        stable = 0;
        n = 0;
        prev = col;
        while (stable < SCAN_DIV + 1 && n < 100) begin
            @(negedge clock);
            n++;
            if (col === prev && col !== 4'd0) stable++;
            else stable = 0;
            prev = col;
        end
        check_eq("reach_debounce", stable >= SCAN_DIV + 1, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_col", col, 4'd0);
        check_eq("async_rst_valid", key_valid, 1'b0);
        check_eq("async_rst_code", key_code, 4'd0);
        check_eq("async_rst_overrun", overrun, 1'b0);
        @(negedge clock);
        key_down = 1'b0;
        tick(3);
        reset = 1'b1;
        n = 0;
        while (col === 4'd0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check_eq("restart_col0", col, 4'b0001);
        tick(60);
        check_eq("pending_discarded", key_valid, 1'b0);

        // Disable while a key is held: columns park, key stays
        press(2'd1, 2'd2);
        wait_valid(lat);
        check_eq("hold_latency_ok", lat <= LAT_MAX, 1'b1);
        check_eq("hold_code", key_code, 4'b0110);
        tick(5);
        enable = 1'b0;
        tick(1);
        check_eq("disable_col", col, 4'd0);
        check_eq("disable_valid", key_valid, 1'b1);
        check_eq("disable_code", key_code, 4'b0110);
        tick(20);
        check_eq("parked_col", col, 4'd0);
        key_down = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL provide parameter SCAN_DIV, default 50_000, clocks each column is driven before its rows are sampled (minimum 2).
REQ-002 SHALL provide parameter DEBOUNCE_MAX, default 999_999, clocks of press and release debounce (minimum 1).
REQ-003 SHALL provide port clock  input  1  system clock; all logic on rising edge.
REQ-004 SHALL provide port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port enable  input  1  scan enable; low parks the scanner.
REQ-006 SHALL provide port row  input  4  raw keypad rows, active-high, asynchronous to clock.
REQ-007 SHALL provide port col  output  4  keypad column drive, one-hot active-high.
REQ-008 SHALL provide port key_code  output  4  code of the last accepted key.
REQ-009 SHALL provide port key_valid  output  1  key_code holds an unconsumed key.
REQ-010 SHALL provide port key_ack  input  1  consumer acknowledge of key_valid.
REQ-011 SHALL provide port overrun  output  1  sticky: a key was lost because key_valid was still set.

Function
REQ-012 SHALL pass row through a 2-flop synchronizer (row_s); all decisions use row_s only.
REQ-013 SHALL implement states IDLE, SCAN, DEBOUNCE, PRESSED, HOLD, RELEASE.
REQ-014 IDLE: col=0000, counters cleared; enable=1 -> SCAN with col=0001.
REQ-015 Any state with enable=0 -> IDLE at next edge; key_valid, key_code, overrun unaffected.
REQ-016 SCAN: dwell counter counts 0..SCAN_DIV-1 per column; at count SCAN_DIV-1 row_s is sampled.
REQ-017 SCAN sample with row_s exactly one-hot -> latch row_s and column index, go DEBOUNCE, col held.
REQ-018 SCAN sample with row_s zero or multi-bit -> rotate col 0001->0010->0100->1000->0001, counter to 0.
REQ-019 DEBOUNCE: count DEBOUNCE_MAX clocks with col held; at terminal, row_s equal to latched row -> PRESSED, else SCAN on the next column.
REQ-020 PRESSED: one cycle; key_code source = {row index[1:0], col index[1:0]} (row bit n -> index n, col bit m -> index m); next state HOLD.
REQ-021 In PRESSED, key_valid=0, or key_valid=1 with key_ack=1 in the same cycle -> key_code loaded, key_valid=1 next cycle.
REQ-022 In PRESSED, key_valid=1 with key_ack=0 -> key_code not overwritten, overrun set to 1.
REQ-023 key_valid=1 and key_ack=1 (outside REQ-021 case) -> key_valid=0 next cycle; key_ack with key_valid=0 ignored.
REQ-024 overrun SHALL clear on any cycle with key_valid=1 and key_ack=1, unless REQ-022 sets it in that same cycle (set wins).
REQ-025 HOLD: col held; row_s==0000 -> RELEASE; no further key emitted while held (no auto-repeat).
REQ-026 RELEASE: count DEBOUNCE_MAX clocks; at terminal, row_s==0000 -> SCAN on next column, else HOLD.
REQ-027 Debounce counter SHALL be width ceil(log2(DEBOUNCE_MAX+1)), cleared on each entry to DEBOUNCE/RELEASE, never wraps.
REQ-028 Press latency: stable press -> key_valid high no later than 2 + 4*SCAN_DIV + DEBOUNCE_MAX + 2 clocks.

Reset
REQ-029 reset low SHALL asynchronously force state IDLE, col=0000, key_code=0000, key_valid=0, overrun=0, all counters and synchronizer flops 0.
REQ-030 reset low mid-scan or mid-debounce SHALL discard the pending key; after release with enable=1, scanning restarts at col=0001.

Verification (SCAN_DIV=4, DEBOUNCE_MAX=8)
REQ-031 Bench SHALL check: reset, enable=1, row=0 -> col cycles 0001,0010,0100,1000 each for 4 clocks; key_valid stays 0.
REQ-032 Bench SHALL check: row=0100 held while col=0010 -> key_code=1001, key_valid pulses high until key_ack, exactly one key per press.
REQ-033 Bench SHALL check: 3-clock glitch row=0001 during col=0001 -> returns to SCAN, key_valid stays 0.
REQ-034 Bench SHALL check: two presses with no key_ack -> first key_code retained, overrun=1; key_ack -> key_valid=0, overrun=0.
REQ-035 Bench SHALL check: row=0011 during any column -> ignored, scanning continues, no key.
REQ-036 Bench SHALL check: reset asserted in DEBOUNCE -> all outputs reset immediately; enable=0 in HOLD -> col=0000, key_valid kept.
